// File: rtl/rv32i_pkg.sv
// Shared RV32 definitions: default data width, instruction register-field
// positions and a decoder for the rs1/rs2/rd fields.
package rv32i_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned RS1_LSB  = 15;
   localparam int unsigned RS2_LSB  = 20;
   localparam int unsigned RD_LSB   = 7;
   localparam int unsigned REG_W    = 5;

   typedef logic [REG_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

   typedef struct packed {
      reg_addr_t rs1;
      reg_addr_t rs2;
      reg_addr_t rd;
   } reg_fields_t;

   function automatic reg_fields_t decode_fields(input logic [31:0] inst);
      reg_fields_t f;
      f.rs1 = inst[RS1_LSB +: REG_W];
      f.rs2 = inst[RS2_LSB +: REG_W];
      f.rd  = inst[RD_LSB  +: REG_W];
      return f;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy vector with set/clear priority and
// read-after-write hazard detection for the two source operands.
module regfile_scoreboard
   import rv32i_pkg::*;
#(
   parameter int unsigned NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  reg_addr_t        rs1,
   input  reg_addr_t        rs2,
   input  reg_addr_t        rd,
   input  logic             rs1_ok,
   input  logic             rs2_ok,
   input  logic             issue,
   input  logic             clr,
   input  reg_addr_t        wr_addr,
   input  logic             mask1,
   input  logic             mask2,
   output logic             hazard,
   output logic [NREGS-1:0] busy
);

   localparam int unsigned AW = $clog2(NREGS);

   logic pend1;
   logic pend2;
   logic set;

   // A bypassed operand is satisfied by this cycle's writeback, so its term is masked.
   assign pend1  = rs1_ok && (rs1 != REG_ZERO) && busy[rs1[AW-1:0]] && !mask1;
   assign pend2  = rs2_ok && (rs2 != REG_ZERO) && busy[rs2[AW-1:0]] && !mask2;
   assign hazard = pend1 || pend2;
   assign set    = issue && !hazard && (rd != REG_ZERO);

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         if (clr) busy[wr_addr[AW-1:0]] <= 1'b0;
         // Later assignment wins: a new pending write outranks the retiring one.
         if (set) busy[rd[AW-1:0]] <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// RV32I/RV32E register file with pending-write scoreboard and writeback pulse.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             issue_wr,
   input  logic             regwr,
   input  logic [4:0]       wr_addr,
   input  logic [XLEN-1:0]  wrdata,
   output logic [XLEN-1:0]  rs1data,
   output logic [XLEN-1:0]  rs2data,
   output logic             hazard,
   output logic [NREGS-1:0] busy,
   output logic             wb_update,
   output logic             illegal_reg
);

   localparam int unsigned AW = $clog2(NREGS);

   // Only 16 and 32 registers are supported; with 16, bit 4 marks an illegal address.
   function automatic logic legal(input reg_addr_t a);
      return (NREGS == 32) || !a[4];
   endfunction

   reg_fields_t f;
   logic        rs1_ok;
   logic        rs2_ok;
   logic        rd_ok;
   logic        wr_en;
   logic        byp1;
   logic        byp2;
   logic        unused_inst_bits;

   logic [XLEN-1:0] regs [NREGS];

   assign f           = decode_fields(inst);
   assign rs1_ok      = legal(f.rs1);
   assign rs2_ok      = legal(f.rs2);
   assign rd_ok       = legal(f.rd);
   assign illegal_reg = !(rs1_ok && rs2_ok && rd_ok);
   assign wr_en       = regwr && legal(wr_addr) && (wr_addr != REG_ZERO);

   assign unused_inst_bits = ^{inst[31:25], inst[14:12], inst[6:0]};

`ifdef REGFILE_BYPASS_EN
   assign byp1 = wr_en && (wr_addr == f.rs1);
   assign byp2 = wr_en && (wr_addr == f.rs2);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         wb_update <= 1'b0;
      end else begin
         if (wr_en) regs[wr_addr[AW-1:0]] <= wrdata;
         wb_update <= wr_en;
      end
   end

   always_comb begin
      rs1data = '0;
      if (byp1) rs1data = wrdata;
      else if (rs1_ok && (f.rs1 != REG_ZERO)) rs1data = regs[f.rs1[AW-1:0]];
   end

   always_comb begin
      rs2data = '0;
      if (byp2) rs2data = wrdata;
      else if (rs2_ok && (f.rs2 != REG_ZERO)) rs2data = regs[f.rs2[AW-1:0]];
   end

   regfile_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .rs1     (f.rs1),
      .rs2     (f.rs2),
      .rd      (f.rd),
      .rs1_ok  (rs1_ok),
      .rs2_ok  (rs2_ok),
      .issue   (issue_wr && !illegal_reg),
      .clr     (wr_en),
      .wr_addr (wr_addr),
      .mask1   (byp1),
      .mask2   (byp2),
      .hazard  (hazard),
      .busy    (busy)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against a 32- and a 16-register DUT.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int S_RS1 = 0, S_RS2 = 1, S_HAZ = 2, S_BUSY = 3, S_WB = 4, S_ILL = 5;
   localparam int S_RS1_16 = 8, S_RS2_16 = 9, S_BUSY_16 = 11, S_WB_16 = 12, S_ILL_16 = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        issue_wr;
   logic        regwr;
   logic [4:0]  wr_addr;
   logic [31:0] wrdata;

   logic [31:0] rs1data, rs2data, rs1data16, rs2data16;
   logic        hazard, wb_update, illegal_reg;
   logic        hazard16, wb_update16, illegal_reg16;
   logic [31:0] busy;
   logic [15:0] busy16;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst(rst), .inst(inst), .issue_wr(issue_wr), .regwr(regwr),
      .wr_addr(wr_addr), .wrdata(wrdata), .rs1data(rs1data), .rs2data(rs2data),
      .hazard(hazard), .busy(busy), .wb_update(wb_update), .illegal_reg(illegal_reg)
   );

   regfile_sb #(.XLEN(32), .NREGS(16)) dut16 (
      .clk(clk), .rst(rst), .inst(inst), .issue_wr(issue_wr), .regwr(regwr),
      .wr_addr(wr_addr), .wrdata(wrdata), .rs1data(rs1data16), .rs2data(rs2data16),
      .hazard(hazard16), .busy(busy16), .wb_update(wb_update16), .illegal_reg(illegal_reg16)
   );

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         S_RS1:     return rs1data;
         S_RS2:     return rs2data;
         S_HAZ:     return 32'(hazard);
         S_BUSY:    return busy;
         S_WB:      return 32'(wb_update);
         S_ILL:     return 32'(illegal_reg);
         S_RS1_16:  return rs1data16;
         S_RS2_16:  return rs2data16;
         S_BUSY_16: return 32'(busy16);
         S_WB_16:   return 32'(wb_update16);
         S_ILL_16:  return 32'(illegal_reg16);
         default:   return 32'hxxxx_xxxx;
      endcase
   endfunction

   function automatic logic [31:0] mk(input int rs1, input int rs2, input int rd);
      logic [4:0] a, b, d;
      a = rs1[4:0];
      b = rs2[4:0];
      d = rd[4:0];
      return {7'b0, b, a, 3'b0, d, 7'h33};
   endfunction

   task automatic exp(input string name, input int sel, input logic [31:0] v);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = v;
      q.push_back(c);
   endtask

   task automatic step(input logic r, input logic [31:0] i, input logic iw,
                       input logic rw, input logic [4:0] wa, input logic [31:0] wd);
      @(posedge clk);
      #1;
      rst = r; inst = i; issue_wr = iw; regwr = rw; wr_addr = wa; wrdata = wd;
   endtask

   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] a;
      while (q.size() > 0) begin
         c = q.pop_front();
         a = actual(c.sel);
         n_cmp++;
         if (a !== c.exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", c.name, a, c.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b0; inst = '0; issue_wr = 1'b0; regwr = 1'b0; wr_addr = '0; wrdata = '0;
      repeat (2) @(posedge clk);

      step(1, mk(2,0,0), 0, 0, 0, 0);
      exp("reset_rs1", S_RS1, 0); exp("reset_busy", S_BUSY, 0);
      exp("reset_wb", S_WB, 0); exp("reset_haz", S_HAZ, 0); exp("reset_busy16", S_BUSY_16, 0);

      step(1, mk(2,0,0), 0, 1, 2, 32'hFFFF_FFFF);
      exp("x2_wr_cycle_rs1", S_RS1, BYP ? 32'hFFFF_FFFF : 32'h0);
      exp("x2_wr_cycle_wb", S_WB, 0);

      step(1, mk(2,0,0), 0, 0, 0, 0);
      exp("x2_read", S_RS1, 32'hFFFF_FFFF); exp("x2_wb_pulse", S_WB, 1);
      exp("x2_read16", S_RS1_16, 32'hFFFF_FFFF);

      step(1, mk(2,0,0), 0, 0, 0, 0);
      exp("x2_wb_one_cycle", S_WB, 0);

      step(1, mk(0,0,0), 0, 1, 0, 32'hDEAD_BEEF);
      exp("x0_wr_cycle_rs1", S_RS1, 0);

      step(1, mk(0,0,0), 0, 0, 0, 0);
      exp("x0_read", S_RS1, 0); exp("x0_no_wb", S_WB, 0);

      step(1, mk(0,0,5), 1, 0, 0, 0);
      exp("issue5_haz", S_HAZ, 0); exp("issue5_busy_pre", S_BUSY, 0);

      step(1, mk(5,0,0), 0, 0, 0, 0);
      exp("raw5_haz", S_HAZ, 1); exp("raw5_busy", S_BUSY, 32'h20);
      exp("raw5_busy16", S_BUSY_16, 32'h20);

      step(1, mk(5,0,0), 0, 1, 5, 32'h1234);
      exp("wb5_haz", S_HAZ, BYP ? 32'h0 : 32'h1);
      exp("wb5_rs1", S_RS1, BYP ? 32'h1234 : 32'h0);
      exp("wb5_busy", S_BUSY, 32'h20);

      step(1, mk(5,0,0), 0, 0, 0, 0);
      exp("post5_haz", S_HAZ, 0); exp("post5_rs1", S_RS1, 32'h1234);
      exp("post5_busy", S_BUSY, 0); exp("post5_wb", S_WB, 1);

      step(1, mk(0,0,7), 1, 0, 0, 0);
      exp("issue7_busy_pre", S_BUSY, 0);

      step(1, mk(0,0,7), 1, 1, 7, 32'h77);
      exp("setclr7_busy_pre", S_BUSY, 32'h80); exp("setclr7_haz", S_HAZ, 0);

      step(1, mk(7,0,9), 1, 0, 0, 0);
      exp("setclr7_set_wins", S_BUSY, 32'h80); exp("stall7_haz", S_HAZ, 1);
      exp("setclr7_wb", S_WB, 1);

      step(1, mk(0,0,0), 0, 1, 3, 32'h33);
      exp("stalled_issue_ignored", S_BUSY, 32'h80);

      step(1, mk(3,4,0), 0, 1, 4, 32'h44);
      exp("b2b_wb1", S_WB, 1); exp("b2b_rs1", S_RS1, 32'h33);
      exp("b2b_rs2_wr_cycle", S_RS2, BYP ? 32'h44 : 32'h0);

      step(1, mk(3,4,0), 0, 0, 0, 0);
      exp("b2b_wb2", S_WB, 1); exp("b2b_rs2", S_RS2, 32'h44);

      step(1, mk(2,20,0), 0, 0, 0, 0);
      exp("b2b_wb_drop", S_WB, 0); exp("ill16_flag", S_ILL_16, 1);
      exp("ill16_rs2", S_RS2_16, 0); exp("ill32_flag", S_ILL, 0);
      exp("x20_unwritten", S_RS2, 0);

      step(1, mk(4,20,0), 0, 1, 20, 32'hAAAA);
      exp("ill16_wr_cycle_rs2", S_RS2_16, 0);
      exp("x20_wr_cycle_rs2", S_RS2, BYP ? 32'hAAAA : 32'h0);

      step(1, mk(4,20,0), 0, 0, 0, 0);
      exp("ill16_no_wb", S_WB_16, 0); exp("x20_wb", S_WB, 1);
      exp("ill16_no_alias_x4", S_RS1_16, 32'h44); exp("x20_read", S_RS2, 32'hAAAA);

      step(1, mk(0,0,3), 1, 0, 0, 0);
      step(1, mk(0,0,9), 1, 0, 0, 0);
      exp("busy3_pre", S_BUSY, 32'h88);
      step(1, mk(0,0,0), 0, 0, 0, 0);
      exp("busy_3_7_9", S_BUSY, 32'h288); exp("busy16_3_7_9", S_BUSY_16, 32'h288);

      step(0, mk(0,0,10), 1, 1, 6, 32'h66);
      exp("pre_reset_busy", S_BUSY, 32'h288);

      step(1, mk(2,3,0), 0, 0, 0, 0);
      exp("mid_reset_busy", S_BUSY, 0); exp("mid_reset_wb", S_WB, 0);
      exp("mid_reset_rs1", S_RS1, 0); exp("mid_reset_rs2", S_RS2, 0);
      exp("mid_reset_busy16", S_BUSY_16, 0); exp("mid_reset_rs1_16", S_RS1_16, 0);

      step(1, mk(6,4,0), 0, 1, 3, 32'h55);
      exp("reset_wins_wr", S_RS1, 0); exp("reset_wins_x4", S_RS2, 0);

      step(1, mk(3,0,0), 0, 0, 0, 0);
      exp("post_reset_wr", S_RS1, 32'h55); exp("post_reset_busy", S_BUSY, 0);
      exp("post_reset_wb", S_WB, 1);

      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: actual=%0d pending required=0 pending", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised RV32I/RV32E integer register file with a built-in pending-write scoreboard and optional write-to-read bypass. Sits between decode and writeback: decodes rs1/rs2/rd from the instruction word, serves two combinational read ports, and flags read-after-write hazards so decode can stall. It also emits a one-cycle writeback-commit pulse.

## Interface
Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, architectural register count; legal values 32 (RV32I) and 16 (RV32E).
- AW, $clog2(NREGS), derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- inst  in  32  instruction word; rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
- issue_wr  in  1  inst is issued this cycle and will write rd.
- regwr  in  1  writeback strobe.
- wr_addr  in  5  writeback destination register.
- wrdata  in  XLEN  writeback data.
- rs1data  out  XLEN  combinational read of rs1.
- rs2data  out  XLEN  combinational read of rs2.
- hazard  out  1  rs1 or rs2 has a pending write; decode must stall.
- busy  out  NREGS  scoreboard vector; bit n set means a write to xn is pending.
- wb_update  out  1  registered one-cycle pulse after a committed write.
- illegal_reg  out  1  some field of inst (rs1, rs2 or rd) addresses a register >= NREGS.

## Operation
- Reset (rst = 0 at a clock edge): all registers, busy, wb_update and the internal issue state clear to 0. Reset wins over regwr and issue_wr in the same cycle.
- x0 reads 0 always. Writes to x0 are dropped and raise no wb_update. x0 is never marked busy.
- Read ports are combinational from inst. An out-of-range address reads 0.
- Scoreboard set: busy[rd] is set on the edge where issue_wr = 1, hazard = 0, rd != 0, and illegal_reg = 0.
  - When hazard = 1, issue_wr is ignored; the stalled instruction must present issue_wr again.
- Scoreboard clear: busy[wr_addr] is cleared on the edge where regwr = 1.
- Write to a non-busy register: the write is accepted and busy stays 0.
- Set and clear on the same register in the same cycle: the set wins and busy stays 1, so the new pending write takes precedence.
- hazard = (busy[rs1] & rs1 != 0) | (busy[rs2] & rs2 != 0), less any term cancelled by bypass (see Configuration).
- wb_update goes to 1 on the edge after any regwr with wr_addr != 0 and in range, and is 1 for exactly one cycle per write. Back-to-back writes hold it high.
- For NREGS = 16, addresses use bits [3:0]. Any address with bit 4 set asserts illegal_reg; writes to such an address are dropped.

## Timing
- Read latency: 0 cycles (combinational from inst and register state).
- Write latency: data is visible on the read ports from the cycle after the regwr edge (without bypass).
- Scoreboard: busy reflects set/clear one cycle after the qualifying edge.
- wb_update: 1 cycle after the regwr edge.
- Mid-operation reset: all pending writes are forgotten. A regwr arriving after reset still writes the register but clears no busy bit.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If regwr = 1 and wr_addr == rs1 (or rs2), the port returns wrdata in the same cycle.
  - The matching hazard term is masked, so a dependent instruction can issue in the writeback cycle.
- REGFILE_BYPASS_EN undefined:
  - The port returns the old register value.
  - hazard stays asserted until busy clears, one cycle after writeback.

## Structure
- Shared package rv32i_pkg holds:
  - XLEN default.
  - Instruction field bit positions (RS1_LSB = 15, RS2_LSB = 20, RD_LSB = 7, 5-bit width).
  - REG_ZERO = 0.
- Sub-module regfile_scoreboard (NREGS parameter): holds the busy vector and implements the set/clear/priority rules and the hazard logic. The top level holds storage, read muxes and bypass.

## Test plan
- Reset, then write 0xFFFFFFFF to x2 (regwr = 1, wr_addr = 2) -> next cycle rs1data = 0xFFFFFFFF when inst.rs1 = 2; wb_update is high for exactly 1 cycle.
- Write 0xDEADBEEF to x0 -> rs1data = 0 with rs1 = 0, and wb_update stays 0.
- issue_wr with rd = 5, then inst with rs1 = 5 -> hazard = 1 and busy[5] = 1. Then regwr to x5 with 0x1234:
  - With REGFILE_BYPASS_EN: hazard = 0 and rs1data = 0x1234 in that cycle.
  - Without it: hazard clears and rs1data = 0x1234 one cycle later.
- Same cycle, issue_wr with rd = 7 and regwr with wr_addr = 7 while busy[7] = 1 -> busy[7] remains 1.
- NREGS = 16, inst with rs2 = 20 -> illegal_reg = 1 and rs2data = 0. A regwr to wr_addr = 20 changes no register and leaves wb_update at 0.
- busy[3] = 1 and busy[9] = 1, assert rst = 0 for one edge -> busy = 0, wb_update = 0, all registers read 0.
